// File: rtl/hazard_sequencer.sv
// Hazard and stall controller for the 5-stage RV32 core: forwarding selects,
// load-use and branch handling, MUL/DIV start/done sequencing with a timeout.
module hazard_sequencer #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rs1e,
  input  logic [4:0]       rs2e,
  input  logic [4:0]       rde,
  input  logic             resultsrce0,
  input  logic             pcsrce,
  input  logic             mdu_op_e,
  input  logic             mdu_done,
  input  logic [4:0]       rdm,
  input  logic             regwritem,
  input  logic [4:0]       rdw,
  input  logic             regwritew,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             flushd,
  output logic             flushe,
  output logic             flushm,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic             mdu_start,
  output logic             mdu_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(MDU_TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic abort;
  logic lwstall;
  logic mdustall;

  assign abort    = (state_q == BUSY) && (tmo_q == TW'(MDU_TIMEOUT - 1));
  assign lwstall  = resultsrce0 && (rde != 5'd0) && ((rs1d == rde) || (rs2d == rde));
  assign mdustall = mdu_op_e && !mdu_done && !abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Timeout counter holds the number of cycles the op has been outstanding,
  // the start cycle included, so MDU_TIMEOUT cycles elapse before abort.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (mdu_op_e) begin
          state_d = BUSY;
          tmo_d   = TW'(1);
        end else begin
          tmo_d = '0;
        end
      end
      BUSY: begin
        if (mdu_done) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (abort) begin
          state_d = IDLE;
          tmo_d   = '0;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tmo_d   = '0;
      end
    endcase
  end

  always_comb begin
    mdu_start = (state_q == IDLE) && mdu_op_e && !reset;
    stallf    = 1'b0;
    stalld    = 1'b0;
    stalle    = 1'b0;
    flushd    = 1'b0;
    flushe    = 1'b0;
    flushm    = 1'b0;
    if (mdustall) begin
      stallf = 1'b1;
      stalld = 1'b1;
      stalle = 1'b1;
      flushm = 1'b1;
    end else if (pcsrce) begin
      flushd = 1'b1;
      flushe = 1'b1;
    end else if (lwstall) begin
      stallf = 1'b1;
      stalld = 1'b1;
      flushe = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallf)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flushd || flushe)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // M-stage result is newer than W, so it wins when both match.
  always_comb begin
    forwardae = 2'b00;
    forwardbe = 2'b00;
    if (regwritem && (rdm != 5'd0) && (rdm == rs1e))
      forwardae = 2'b10;
    else if (regwritew && (rdw != 5'd0) && (rdw == rs1e))
      forwardae = 2'b01;
    if (regwritem && (rdm != 5'd0) && (rdm == rs2e))
      forwardbe = 2'b10;
    else if (regwritew && (rdw != 5'd0) && (rdw == rs2e))
      forwardbe = 2'b01;
  end

  assign mdu_error = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
